// File: rtl/sap1_ring_sequencer.sv
// Hardwired six-T-state ring controller for the SAP-1 datapath, with
// run/single-step gating, sticky halt and a retired-instruction counter.
module sap1_ring_sequencer #(
  parameter int               OPC_W   = 5,
  parameter logic [OPC_W-1:0] OPC_LDA = 5'h00,
  parameter logic [OPC_W-1:0] OPC_ADD = 5'h01,
  parameter logic [OPC_W-1:0] OPC_SUB = 5'h02,
  parameter logic [OPC_W-1:0] OPC_OUT = 5'h03,
  parameter logic [OPC_W-1:0] OPC_HLT = 5'h1F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic [OPC_W-1:0] opcode,
  output logic             ep,
  output logic             cp,
  output logic             ei,
  output logic             ea,
  output logic             su,
  output logic             ad,
  output logic             eu,
  output logic             lm_n,
  output logic             ce_n,
  output logic             li_n,
  output logic             la_n,
  output logic             lb_n,
  output logic             lo_n,
  output logic [5:0]       t_state,
  output logic             halted,
  output logic             instr_done,
  output logic [7:0]       instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t     state_q, state_d;
  logic       step_q;
  logic [7:0] count_q, count_d;
  logic       step_rise;
  logic       is_lda, is_add, is_sub, is_out, is_hlt;

  assign step_rise = step & ~step_q;
  assign is_lda    = (opcode == OPC_LDA);
  assign is_add    = (opcode == OPC_ADD);
  assign is_sub    = (opcode == OPC_SUB);
  assign is_out    = (opcode == OPC_OUT);
  assign is_hlt    = (opcode == OPC_HLT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      step_q  <= 1'b0;
      count_q <= 8'h00;
    end else begin
      state_q <= state_d;
      step_q  <= step;
      count_q <= count_d;
    end
  end

  // Step edges arriving outside IDLE fall through unused: nothing is queued.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: if (run || step_rise) state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3:   state_d = S_T4;
      S_T4:   state_d = is_hlt ? S_HALT : S_T5;
      S_T5:   state_d = S_T6;
      S_T6: begin
        count_d = count_q + 8'd1;
        state_d = run ? S_T1 : S_IDLE;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ep   = 1'b0;
    cp   = 1'b0;
    ei   = 1'b0;
    ea   = 1'b0;
    su   = 1'b0;
    ad   = 1'b0;
    eu   = 1'b0;
    lm_n = 1'b1;
    ce_n = 1'b1;
    li_n = 1'b1;
    la_n = 1'b1;
    lb_n = 1'b1;
    lo_n = 1'b1;
    case (state_q)
      S_T1: begin
        ep   = 1'b1;
        lm_n = 1'b0;
      end
      S_T2: cp = 1'b1;
      S_T3: begin
        ce_n = 1'b0;
        li_n = 1'b0;
      end
      S_T4: begin
        if (is_lda || is_add || is_sub) begin
          ei   = 1'b1;
          lm_n = 1'b0;
        end else if (is_out) begin
          ea   = 1'b1;
          lo_n = 1'b0;
        end
      end
      S_T5: begin
        if (is_lda) begin
          ce_n = 1'b0;
          la_n = 1'b0;
        end else if (is_add || is_sub) begin
          ce_n = 1'b0;
          lb_n = 1'b0;
        end
      end
      // ALU is combinational, so the accumulator captures its own result here.
      S_T6: begin
        if (is_add) begin
          ad   = 1'b1;
          eu   = 1'b1;
          la_n = 1'b0;
        end else if (is_sub) begin
          su   = 1'b1;
          eu   = 1'b1;
          la_n = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    t_state = 6'b000000;
    case (state_q)
      S_T1:    t_state = 6'b000001;
      S_T2:    t_state = 6'b000010;
      S_T3:    t_state = 6'b000100;
      S_T4:    t_state = 6'b001000;
      S_T5:    t_state = 6'b010000;
      S_T6:    t_state = 6'b100000;
      default: t_state = 6'b000000;
    endcase
  end

  assign halted      = (state_q == S_HALT);
  assign instr_done  = (state_q == S_T6);
  assign instr_count = count_q;

endmodule

// File: tb/tb_sap1_ring_sequencer.sv
// Bench: a small SAP-1 datapath fed by the sequencer's controls, plus a
// phase-level reference model compared on every falling edge.
module tb_sap1_ring_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic [4:0] opcode;
  logic       ep, cp, ei, ea, su, ad, eu;
  logic       lm_n, ce_n, li_n, la_n, lb_n, lo_n;
  logic [5:0] t_state;
  logic       halted, instr_done;
  logic [7:0] instr_count;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit cmp_en = 1'b0;

  logic [8:0] mem [16];
  logic [3:0] pc, mar;
  logic [8:0] ir, acc, breg, oreg, bus, alu;
  logic [12:0] ctrl;

  int         m_phase;
  logic       m_step;
  logic [7:0] m_count;

  localparam logic [12:0] EP = 13'h1000, CP = 13'h0800, EI = 13'h0400, EA = 13'h0200;
  localparam logic [12:0] SU = 13'h0100, AD = 13'h0080, EU = 13'h0040, LM = 13'h0020;
  localparam logic [12:0] CE = 13'h0010, LI = 13'h0008, LA = 13'h0004, LB = 13'h0002;
  localparam logic [12:0] LO = 13'h0001, IDLE_LEVELS = 13'h003F;

  sap1_ring_sequencer dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .opcode(opcode),
    .ep(ep), .cp(cp), .ei(ei), .ea(ea), .su(su), .ad(ad), .eu(eu),
    .lm_n(lm_n), .ce_n(ce_n), .li_n(li_n), .la_n(la_n), .lb_n(lb_n), .lo_n(lo_n),
    .t_state(t_state), .halted(halted), .instr_done(instr_done),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign opcode = ir[8:4];
  assign ctrl   = {ep, cp, ei, ea, su, ad, eu, lm_n, ce_n, li_n, la_n, lb_n, lo_n};

  always_comb begin
    alu = su ? (acc - breg) : (acc + breg);
    bus = 9'h000;
    if (ep)         bus = {5'b0, pc};
    else if (!ce_n) bus = mem[mar];
    else if (ei)    bus = {5'b0, ir[3:0]};
    else if (ea)    bus = acc;
    else if (eu)    bus = alu;
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= 4'h0; mar <= 4'h0; ir <= 9'h000;
      acc <= 9'h000; breg <= 9'h000; oreg <= 9'h000;
    end else begin
      if (cp)    pc   <= pc + 4'h1;
      if (!lm_n) mar  <= bus[3:0];
      if (!li_n) ir   <= bus;
      if (!la_n) acc  <= bus;
      if (!lb_n) breg <= bus;
      if (!lo_n) oreg <= bus;
    end
  end

  // Phase 0 = idle, 1..6 = T1..T6, 7 = halted.
  function automatic int next_phase(int ph, logic r, logic rise, logic [4:0] opc);
    if (ph == 0) return (r || rise) ? 1 : 0;
    if (ph == 7) return 7;
    if (ph == 4 && opc == 5'h1F) return 7;
    if (ph == 6) return r ? 1 : 0;
    return ph + 1;
  endfunction

  function automatic logic [12:0] model_ctrl(int ph, logic [4:0] opc);
    logic [12:0] act;
    act = 13'h0000;
    case (ph)
      1: act = EP | LM;
      2: act = CP;
      3: act = CE | LI;
      4: if (opc <= 5'h02) act = EI | LM; else if (opc == 5'h03) act = EA | LO;
      5: if (opc == 5'h00) act = CE | LA; else if (opc == 5'h01 || opc == 5'h02) act = CE | LB;
      6: if (opc == 5'h01) act = AD | EU | LA; else if (opc == 5'h02) act = SU | EU | LA;
      default: act = 13'h0000;
    endcase
    return act ^ IDLE_LEVELS;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase <= 0; m_step <= 1'b0; m_count <= 8'h00;
    end else begin
      m_step  <= step;
      m_phase <= next_phase(m_phase, run, step & ~m_step, opcode);
      if (m_phase == 6) m_count <= m_count + 8'd1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst && cmp_en) begin
      check("t_state", {26'b0, t_state},
            (m_phase >= 1 && m_phase <= 6) ? (32'd1 << (m_phase - 1)) : 32'd0);
      check("halted", {31'b0, halted}, {31'b0, m_phase == 7});
      check("instr_done", {31'b0, instr_done}, {31'b0, m_phase == 6});
      check("instr_count", {24'b0, instr_count}, {24'b0, m_count});
      check("ctrl", {19'b0, ctrl}, {19'b0, model_ctrl(m_phase, opcode)});
    end
  end

  always @(negedge clk) if (instr_done) pulses++;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic s);
    run  = r;
    step = s;
  endtask

  task automatic do_reset(input logic r);
    rst = 1'b0;
    applyStimulus(r, 1'b0);
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_t1();
    int n;
    n = 0;
    tick();
    while (t_state != 6'b000001 && n < 50) begin
      tick();
      n++;
    end
    check("wait_t1", {26'b0, t_state}, 32'd1);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, act, exp);
  endtask

  logic [12:0] add_exp [6];

  initial begin
    add_exp[0] = 13'h101F; add_exp[1] = 13'h083F; add_exp[2] = 13'h0027;
    add_exp[3] = 13'h041F; add_exp[4] = 13'h002D; add_exp[5] = 13'h00FB;

    // Reset state
    for (int i = 0; i < 16; i++) mem[i] = 9'h1F0;
    mem[0] = 9'h009; mem[1] = 9'h01A; mem[2] = 9'h02B; mem[3] = 9'h030;
    mem[9] = 9'h001; mem[10] = 9'h002; mem[11] = 9'h001;
    rst = 1'b0;
    tick();
    checkOutput("rst_t_state", {26'b0, t_state}, 32'd0);
    checkOutput("rst_ctrl", {19'b0, ctrl}, {19'b0, IDLE_LEVELS});
    checkOutput("rst_count", {24'b0, instr_count}, 32'd0);
    checkOutput("rst_halted", {31'b0, halted}, 32'd0);
    cmp_en = 1'b1;

    // Program LDA 9 / ADD A / SUB B / OUT / HLT in free-run
    do_reset(1'b1);
    wait_t1();
    repeat (5) tick();
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput($sformatf("add_t%0d", i + 1), {19'b0, ctrl}, {19'b0, add_exp[i]});
    end
    repeat (13) tick();
    checkOutput("prog_oreg", {23'b0, oreg}, 32'h002);
    checkOutput("prog_count", {24'b0, instr_count}, 32'd4);
    repeat (4) tick();
    checkOutput("hlt_halted", {31'b0, halted}, 32'd1);
    repeat (5) tick();
    checkOutput("hlt_count", {24'b0, instr_count}, 32'd4);
    checkOutput("hlt_t_state", {26'b0, t_state}, 32'd0);

    // Single-step mode with undefined opcode 07
    for (int i = 0; i < 16; i++) mem[i] = 9'h070;
    do_reset(1'b0);
    tick();
    applyStimulus(1'b0, 1'b1);
    repeat (10) tick();
    checkOutput("step_idle", {26'b0, t_state}, 32'd0);
    checkOutput("step_count1", {24'b0, instr_count}, 32'd1);
    applyStimulus(1'b0, 1'b0);
    repeat (2) tick();
    applyStimulus(1'b0, 1'b1);
    tick();
    checkOutput("step_t1", {26'b0, t_state}, 32'd1);
    applyStimulus(1'b0, 1'b0);
    tick();
    tick();
    checkOutput("step_t3", {26'b0, t_state}, 32'd4);
    applyStimulus(1'b0, 1'b1);
    for (int i = 4; i <= 6; i++) begin
      tick();
      checkOutput($sformatf("nop_t%0d", i), {19'b0, ctrl}, {19'b0, IDLE_LEVELS});
    end
    checkOutput("nop_done", {31'b0, instr_done}, 32'd1);
    repeat (3) tick();
    checkOutput("step_ignored", {26'b0, t_state}, 32'd0);
    checkOutput("step_count2", {24'b0, instr_count}, 32'd2);
    applyStimulus(1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1);
    tick();
    checkOutput("step_restart", {26'b0, t_state}, 32'd1);
    repeat (7) tick();
    checkOutput("step_count3", {24'b0, instr_count}, 32'd3);
    checkOutput("nop_pc", {28'b0, pc}, 32'd3);

    // Reset asserted during T5 of LDA
    for (int i = 0; i < 16; i++) mem[i] = 9'h070;
    mem[1] = 9'h009; mem[9] = 9'h005;
    do_reset(1'b1);
    wait_t1();
    repeat (10) tick();
    checkOutput("lda_t5", {26'b0, t_state}, 32'd16);
    rst = 1'b0;
    #1;
    checkOutput("midrst_ctrl", {19'b0, ctrl}, {19'b0, IDLE_LEVELS});
    checkOutput("midrst_t_state", {26'b0, t_state}, 32'd0);
    checkOutput("midrst_count", {24'b0, instr_count}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("midrst_t1", {26'b0, t_state}, 32'd1);

    // Counter wrap over 256 NOPs
    for (int i = 0; i < 16; i++) mem[i] = 9'h070;
    do_reset(1'b1);
    wait_t1();
    pulses = 0;
    repeat (255 * 6) tick();
    checkOutput("count_255", {24'b0, instr_count}, 32'd255);
    checkOutput("pulses_255", pulses, 32'd255);
    repeat (6) tick();
    checkOutput("count_wrap", {24'b0, instr_count}, 32'd0);
    checkOutput("pulses_256", pulses, 32'd256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
